fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Program-counter controller that drives the 8-bit PC into the instruction memory and sequences execution of the three resident programs: product at 0, string match at 28, and closest pair at 48. It launches the selected program on Start, then advances or redirects the PC on branch requests from the decode/ALU stage. It freezes the PC on stall and detects the all-zero "done" opcode to finish with a Done/Start handshake.

Parameters:
PC_W, 8, PC and branch-target width
INSTR_W, 9, instruction width from imem
ENTRY0, 8'd0, product program entry address
ENTRY1, 8'd28, string-match entry address
ENTRY2, 8'd48, closest-pair entry address
HALT_OP, 9'b000_000_000, opcode treated as program done

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  level request to launch a program
ProgSel  in  2  program select: 0/1/2 map to ENTRY0/1/2; 3 is invalid
Instr  in  INSTR_W  current instruction from imem (combinational from PC)
BranchTaken  in  1  redirect PC this cycle
Target  in  PC_W  absolute branch target
Stall  in  1  hold PC and state this cycle
PC  out  PC_W  address to imem
Running  out  1  high in RUN
Done  out  1  high in DONE
InstrCount  out  16  retired-instruction count (optional feature)

Behaviour:
- One clock (Clk). Reset is synchronous and active-high.
- Reset: state IDLE; PC=0; Running=0; Done=0; InstrCount=0. Reset mid-RUN or mid-DONE aborts to IDLE the next edge.
- States: IDLE, RUN, DONE. Running and Done are registered decodes of the state.
- IDLE:
  - Start=1 and ProgSel<3: PC<=entry[ProgSel], go to RUN. Running is high the following cycle.
  - Start=1 and ProgSel=3: ignored, stay IDLE, PC unchanged.
  - Stall is ignored in IDLE.
- RUN, priority per cycle is Stall > halt > branch > increment:
  - Stall=1: PC, state and count are held. Instr is not evaluated.
  - Instr==HALT_OP: go to DONE. PC holds the halt address. The halt instruction is not counted.
  - BranchTaken=1: PC<=Target, next cycle. A target equal to PC is legal (self-loop).
  - Otherwise: PC<=PC+1, modulo 2^PC_W (255 wraps to 0, no flag).
  - Start is ignored in RUN.
- DONE:
  - Done=1 and PC is held.
  - Return to IDLE when Start=0. Start held high from launch through completion never retriggers.
  - Done falls in the cycle after Start falls.
- Latency:
  - Start to first valid PC: 1 cycle.
  - Branch: 1 cycle, no delay slot.
  - Halt seen to Done high: 1 cycle.
- BranchTaken and Target are don't-care outside RUN and during Stall.

Optional Feature:
- Macro FETCH_SEQ_INSTR_COUNT_EN.
- When defined:
  - 16-bit InstrCount is cleared on launch.
  - It increments on each non-stalled, non-halt RUN cycle.
  - It saturates at 16'hFFFF and holds its value in DONE and IDLE until the next launch.
- When undefined: InstrCount is tied to 0 and no counter flops are built.

Decomposition:
- Package fetch_pkg:
  - state enum {IDLE, RUN, DONE} as a 2-bit logic typedef.
  - pc_t (logic [PC_W-1:0]) and instr_t (logic [INSTR_W-1:0]).
  - ENTRY0/1/2 and HALT_OP constants, plus an entry lookup function indexed by ProgSel.
- One sub-module, fetch_pc_next: combinational next-PC mux (hold / entry / target / PC+1) driven by state and priority decode. Registers stay in fetch_sequencer.

Test Plan:
- Reset then Start=1 with ProgSel=1 and no branches, Instr nonzero until PC=47 where Instr=0:
  - PC steps 28→47, Done rises 1 cycle after PC=47.
  - InstrCount=19 (feature on).
- RUN ProgSel=0, BranchTaken=1 with Target=8 when PC=4: next PC=8, then 9, 10.
- Simultaneous conditions at PC=30:
  - Stall=1 with BranchTaken=1: PC stays 30, count unchanged.
  - Next cycle Stall=0, Instr=0 with BranchTaken=1: halt wins, DONE, PC=30.
- Start=1 with ProgSel=3: stays IDLE, PC=0, Running=0.
- Start held high through completion: Done held. Start=0 → IDLE next cycle, Done=0, no relaunch.
- PC=255 with no branch/halt → PC=0. Reset asserted mid-RUN at PC=60 → IDLE, PC=0, Running=0 next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, program entry points and halt opcode for the fetch sequencer.
package fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 9;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam pc_t    ENTRY0  = 8'd0;   // product
  localparam pc_t    ENTRY1  = 8'd28;  // string match
  localparam pc_t    ENTRY2  = 8'd48;  // closest pair
  localparam instr_t HALT_OP = 9'b000_000_000;

  // Entry address for a program select; select 3 is never launched, so its value is unused.
  function automatic pc_t entry_addr(input logic [1:0] sel);
    case (sel)
      2'd1:    entry_addr = ENTRY1;
      2'd2:    entry_addr = ENTRY2;
      default: entry_addr = ENTRY0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// fetch_pc_next: combinational next-PC select (entry on launch, target on branch,
// PC+1 on advance, otherwise hold). Priority decode is done by the caller.
module fetch_pc_next
  import fetch_pkg::*;
(
  input  logic       launch,    // IDLE with a valid Start
  input  logic       adv,       // RUN, not stalled, not halting
  input  logic [1:0] prog_sel,
  input  logic       branch,
  input  pc_t        target,
  input  pc_t        pc,
  output pc_t        pc_next
);

  // Hold is the fall-through: covers stall, halt, DONE and idle-without-launch.
  always_comb begin
    pc_next = pc;
    if (launch)
      pc_next = entry_addr(prog_sel);
    else if (adv && branch)
      pc_next = target;
    else if (adv)
      pc_next = pc + pc_t'(1);  // wraps 255 -> 0
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC controller for the three resident programs.
// Optional retired-instruction counter built only when FETCH_SEQ_INSTR_COUNT_EN is defined.
module fetch_sequencer
  import fetch_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [1:0]         ProgSel,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               BranchTaken,
  input  logic [PC_W-1:0]    Target,
  input  logic               Stall,
  output logic [PC_W-1:0]    PC,
  output logic               Running,
  output logic               Done,
  output logic [15:0]        InstrCount
);

  state_t state;
  pc_t    pc_nxt;
  logic   halt, launch, adv;

  assign halt   = (Instr == HALT_OP);
  assign launch = (state == IDLE) && Start && (ProgSel != 2'd3);
  assign adv    = (state == RUN) && !Stall && !halt;

  fetch_pc_next u_pc_next (
    .launch   (launch),
    .adv      (adv),
    .prog_sel (ProgSel),
    .branch   (BranchTaken),
    .target   (Target),
    .pc       (PC),
    .pc_next  (pc_nxt)
  );

  // Control FSM with PC register; Running/Done registered alongside the state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      PC      <= '0;
      Running <= 1'b0;
      Done    <= 1'b0;
    end else begin
      PC <= pc_nxt;
      case (state)
        IDLE: if (launch) begin
          state   <= RUN;
          Running <= 1'b1;
        end
        RUN: if (!Stall && halt) begin
          state   <= DONE;
          Running <= 1'b0;
          Done    <= 1'b1;
        end
        DONE: if (!Start) begin
          state <= IDLE;
          Done  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          Running <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_SEQ_INSTR_COUNT_EN
  logic [15:0] icnt;

  // Retired-instruction counter: cleared on launch, saturating, held outside RUN.
  always_ff @(posedge Clk) begin
    if (Reset)
      icnt <= '0;
    else if (launch)
      icnt <= '0;
    else if (adv && icnt != 16'hFFFF)
      icnt <= icnt + 16'd1;
  end

  assign InstrCount = icnt;
`else
  assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus random traffic; a per-edge reference
// model pushes expected outputs into a queue and a monitor pops and compares them.
module tb_fetch_sequencer;

  typedef struct {
    int pc;
    int running;
    int done;
    int cnt;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  ProgSel = 2'd0;
  logic [8:0]  Instr;
  logic        BranchTaken = 1'b0;
  logic [7:0]  Target = 8'd0;
  logic        Stall = 1'b0;
  logic [7:0]  PC;
  logic        Running, Done;
  logic [15:0] InstrCount;

  logic [8:0] imem [256];
  exp_t       sb_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  assign Instr = imem[PC];

  fetch_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Instr(Instr),
    .BranchTaken(BranchTaken), .Target(Target), .Stall(Stall),
    .PC(PC), .Running(Running), .Done(Done), .InstrCount(InstrCount)
  );

  always #5 Clk = ~Clk;

  // Reference model: mode 0 idle, 1 executing, 2 finished.
  int m_mode = 0;
  int m_pc   = 0;
  int m_cnt  = 0;

  always @(posedge Clk) begin
    exp_t e;
    if (Reset) begin
      m_mode = 0; m_pc = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (Start && ProgSel != 3) begin
        m_pc   = (ProgSel == 0) ? 0 : (ProgSel == 1) ? 28 : 48;
        m_cnt  = 0;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (!Stall) begin
        if (imem[m_pc] == 0) m_mode = 2;
        else begin
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
          m_pc = BranchTaken ? int'(Target) : (m_pc + 1) % 256;
        end
      end
    end else begin
      if (!Start) m_mode = 0;
    end
    e.pc = m_pc;
    e.running = (m_mode == 1) ? 1 : 0;
    e.done = (m_mode == 2) ? 1 : 0;
`ifdef FETCH_SEQ_INSTR_COUNT_EN
    e.cnt = m_cnt;
`else
    e.cnt = 0;
`endif
    sb_q.push_back(e);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare just after each edge.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk("PC", int'(PC), e.pc);
      chk("Running", int'(Running), e.running);
      chk("Done", int'(Done), e.done);
      chk("InstrCount", int'(InstrCount), e.cnt);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Wait (at negedges) until the DUT PC equals v; expiry counts as a failure.
  task automatic wait_pc(input int v, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (int'(PC) == v) return;
      @(negedge Clk);
    end
    chk("wait_pc_timeout", int'(PC), v);
  endtask

  task automatic fill_imem();
    for (int i = 0; i < 256; i++) imem[i] = 9'h100 | 9'(i);
  endtask

  initial begin
    fill_imem();
    imem[47] = 9'd0;
    cyc(2);
    Reset = 1'b0;
    cyc(1);

    // Program 1 runs 28..47 and halts; Start held high through completion.
    Start = 1'b1; ProgSel = 2'd1;
    cyc(25);
    Start = 1'b0;
    cyc(3);

    // Invalid select is ignored.
    Start = 1'b1; ProgSel = 2'd3;
    cyc(3);
    Start = 1'b0;
    cyc(1);

    // Program 0 with a branch at PC=4 to 8.
    Start = 1'b1; ProgSel = 2'd0;
    cyc(1);
    Start = 1'b0;
    wait_pc(4, 10);
    BranchTaken = 1'b1; Target = 8'd8;
    cyc(1);
    BranchTaken = 1'b0;
    cyc(45);

    // Stall beats branch at PC=30, then halt beats branch.
    imem[30] = 9'd0;
    Start = 1'b1; ProgSel = 2'd1;
    cyc(1);
    Start = 1'b0;
    wait_pc(30, 10);
    Stall = 1'b1; BranchTaken = 1'b1; Target = 8'd99;
    cyc(1);
    Stall = 1'b0;
    cyc(1);
    BranchTaken = 1'b0;
    cyc(3);
    fill_imem();

    // Wrap 255 -> 0, then reset mid-run at PC=60.
    Start = 1'b1; ProgSel = 2'd2;
    cyc(1);
    Start = 1'b0;
    wait_pc(50, 10);
    BranchTaken = 1'b1; Target = 8'd254;
    cyc(1);
    BranchTaken = 1'b0;
    wait_pc(3, 10);
    BranchTaken = 1'b1; Target = 8'd60;
    cyc(1);
    BranchTaken = 1'b0;
    chk("pc_before_reset", int'(PC), 60);
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    cyc(2);

    // Random traffic with sparse halts.
    for (int i = 0; i < 256; i++)
      imem[i] = ($urandom_range(0, 15) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
    for (int i = 0; i < 3000; i++) begin
      Reset       = ($urandom_range(0, 199) == 0);
      Start       = ($urandom_range(0, 2) != 0);
      ProgSel     = 2'($urandom_range(0, 3));
      Stall       = ($urandom_range(0, 4) == 0);
      BranchTaken = ($urandom_range(0, 5) == 0);
      Target      = 8'($urandom_range(0, 255));
      cyc(1);
    end
    Reset = 1'b0; Start = 1'b0; Stall = 1'b0; BranchTaken = 1'b0;
    cyc(3);
    chk("scoreboard_leftover", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
